// File: rtl/pulser_pkg.sv
// pulser_pkg: shared constants and the counter-width helper for the pulser block.
//   DEFAULT_PERIOD : default number of clock cycles between pulses
//   cnt_width(n)   : counter width for a period of n, max(1, clog2(n))
package pulser_pkg;

    localparam int DEFAULT_PERIOD = 50_000_000;

    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pulser.sv
// pulser: periodic one-cycle strobe generator with run/hold and synchronous restart.
//   clk_i   : clock, all state updates on the rising edge
//   rst_ni  : asynchronous active-low reset (clears count and pulse)
//   run_i   : count enable; hold count and drop pulse while low
//   clear_i : synchronous restart of the period; beats run and wrap
//   pulse_o : registered strobe, high one cycle per PERIOD counted cycles
//   count_o : current counter value, 0..PERIOD-1
// Define PULSER_ASSERT_EN to compile in the concurrent assertions and an extra
// elaboration check on PERIOD; the synthesized logic is the same either way.
module pulser
    import pulser_pkg::*;
#(
    parameter int PERIOD = DEFAULT_PERIOD
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        run_i,
    input  logic                        clear_i,
    output logic                        pulse_o,
    output logic [cnt_width(PERIOD)-1:0] count_o
);

    localparam int CW = cnt_width(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    if (PERIOD < 1) begin : g_bad_period
        $error("pulser: PERIOD must be at least 1");
    end

    logic [CW-1:0] count_q, count_d;
    logic          pulse_q, pulse_d;

    // Wrap explicitly at LAST so the count never reaches values CW could hold beyond it.
    always_comb begin
        count_d = clear_i ? '0 : !run_i ? count_q : (count_q == LAST) ? '0 : count_q + 1'b1;
        pulse_d = run_i && !clear_i && (count_q == LAST);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

    assign count_o = count_q;
    assign pulse_o = pulse_q;

`ifdef PULSER_ASSERT_EN
    if (((PERIOD - 1) >> CW) != 0) begin : g_bad_width
        $error("pulser: counter width cannot hold PERIOD-1");
    end

    if (PERIOD > 1) begin : g_one_shot
        a_one_shot: assert property (@(posedge clk_i) disable iff (!rst_ni)
            pulse_q |=> !pulse_q);
    end

    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= LAST);

    a_pulse_src: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pulse_q |-> $past(count_q) == LAST);
`else
`endif

endmodule

// File: tb/tb_pulser.sv
// tb_pulser: directed self-checking bench for pulser at PERIOD=50, 1 and 2.
module tb_pulser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst_b_n;
    logic       run;
    logic       clear;
    logic       pulse;
    logic [5:0] count;
    logic       pulse1;
    logic [0:0] count1;
    logic       pulse2;
    logic [0:0] count2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pulser #(.PERIOD(50)) dut (
        .clk_i(clk), .rst_ni(rst_n), .run_i(run), .clear_i(clear),
        .pulse_o(pulse), .count_o(count)
    );

    pulser #(.PERIOD(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_b_n), .run_i(1'b1), .clear_i(1'b0),
        .pulse_o(pulse1), .count_o(count1)
    );

    pulser #(.PERIOD(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_b_n), .run_i(1'b1), .clear_i(1'b0),
        .pulse_o(pulse2), .count_o(count2)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until pulse is seen; n = edges taken, or -1 if the budget runs out.
    task automatic wait_pulse(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (pulse) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int n_pulse;
        int exp_at;
        logic [5:0] prev;
        logic seen;
        rst_n   = 1'b0;
        rst_b_n = 1'b0;
        run     = 1'b1;
        clear   = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_pulse", pulse, 0);
        check("rst_pulse1", pulse1, 0);
        check("rst_pulse2", pulse2, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        // free running: pulses after edges 50, 100, 150
        n_pulse = 0;
        exp_at  = 50;
        prev    = count;
        for (int k = 1; k <= 150; k++) begin
            tick();
            if (pulse) begin
                n_pulse++;
                check("pulse_at", k, exp_at);
                check("pre_pulse_count", prev, 49);
                exp_at += 50;
            end
            prev = count;
        end
        check("n_pulses", n_pulse, 3);
        check("count_after_150", count, 0);
        tick();
        check("pulse_one_cycle", pulse, 0);
        check("count_after_151", count, 1);
        // run=0 hold at 20
        repeat (19) tick();
        check("count_before_hold", count, 20);
        run  = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen |= pulse;
        end
        check("hold_count", count, 20);
        check("hold_pulse", seen, 0);
        run = 1'b1;
        wait_pulse(n);
        check("resume_pulse_edges", n, 30);
        // clear at 30
        repeat (30) tick();
        check("count_before_clear", count, 30);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_count", count, 0);
        wait_pulse(n);
        check("clear_pulse_edges", n, 50);
        // clear wins over run=0
        repeat (5) tick();
        run   = 1'b0;
        clear = 1'b1;
        tick();
        check("clear_no_run", count, 0);
        run   = 1'b1;
        clear = 1'b0;
        // clear at count 49 suppresses the pulse
        repeat (49) tick();
        check("count_49", count, 49);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear49_pulse", pulse, 0);
        check("clear49_count", count, 0);
        wait_pulse(n);
        check("clear49_next", n, 50);
        // async reset mid-cycle at 40
        repeat (40) tick();
        check("count_40", count, 40);
        #2 rst_n = 1'b0;
        #1;
        check("async_count", count, 0);
        check("async_pulse", pulse, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_pulse(n);
        check("post_reset_pulse", n, 50);
        #2 rst_n = 1'b0;
        #1;
        check("async_kills_pulse", pulse, 0);
        tick();
        rst_n = 1'b1;
        // PERIOD=1 and PERIOD=2
        rst_b_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("p1_pulse", pulse1, 1);
            check("p1_count", count1, 0);
            check("p2_pulse", pulse2, (k % 2 == 0) ? 1 : 0);
            check("p2_count", count2, k % 2);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulser.md
PULSER -- requirements
Module: pulser

Interface
REQ-001 Parameter PERIOD, default 50_000_000, number of Clock cycles between successive pulses; legal range 1..2^31-1.
REQ-002 Localparam CW, default max(1, $clog2(PERIOD)), width of the internal counter and the Count output.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Run  input  1  count enable; tie to 1 for free-running operation.
REQ-006 Clear  input  1  synchronous restart of the period.
REQ-007 Pulse  output  1  registered one-cycle strobe, once per PERIOD counted cycles.
REQ-008 Count  output  CW  current counter value, 0..PERIOD-1.
REQ-009 Connect all ports by name; port order carries no meaning.

Function
REQ-010 Count SHALL increment by 1 on each rising edge with Run=1, and wrap from PERIOD-1 to 0.
REQ-011 Pulse SHALL be registered as (Count==PERIOD-1 && Run && !Clear) at each edge; Pulse is high for exactly one cycle.
REQ-012 After Reset release with Run=1, Pulse SHALL first go high after the PERIOD-th rising edge, then every PERIOD edges.
REQ-013 Run=0 SHALL hold Count unchanged and drive Pulse to 0 at the next edge; counting resumes from the held value.
REQ-014 Clear=1 SHALL, at the next edge, set Count=0 and Pulse=0, regardless of Run.
REQ-015 Clear coinciding with Count==PERIOD-1 SHALL suppress that pulse; Clear has priority over wrap.
REQ-016 PERIOD=1 SHALL hold Count at 0 and drive Pulse=1 on every edge with Run=1 and Clear=0.
REQ-017 PERIOD<1 SHALL cause an elaboration-time error.
REQ-018 Count SHALL never exceed PERIOD-1, including when CW could represent larger values.
REQ-019 The design SHALL have no combinational path from any input to Pulse or Count.

Reset
REQ-020 Reset=0 SHALL immediately force Count=0 and Pulse=0, with no clock edge required.
REQ-021 Reset asserted mid-period SHALL discard progress; the next period starts from 0 after release.
REQ-022 The first counting edge SHALL be the first rising edge with Reset=1.

Configuration
REQ-023 Macro PULSER_ASSERT_EN defined SHALL compile in concurrent assertions: Pulse never high on two consecutive edges when PERIOD>1; Count<PERIOD at all times; Pulse implies the previous Count==PERIOD-1. It SHALL also compile in an elaboration check on PERIOD.
REQ-024 Without PULSER_ASSERT_EN, the checks SHALL be absent and the synthesized logic SHALL be identical.

Structure
REQ-025 Package pulser_pkg SHALL hold the default-period constant (50_000_000) and the counter-width function, max(1, clog2(n)).
REQ-026 The block SHALL be a single module; no sub-module is needed.

Verification (PERIOD=50 unless noted)
REQ-027 Reset low for 2 cycles, then release with Run=1 and Clear=0 -> Pulse high only after edges 50, 100, 150; Count reads 49 just before each pulse.
REQ-028 Run=0 for 10 cycles at Count=20 -> Count holds at 20 and Pulse stays 0; the next pulse arrives 10 cycles later than free-running.
REQ-029 Clear pulsed at Count=30 -> Count=0 at the next edge; the next Pulse arrives 50 edges after the Clear edge.
REQ-030 Reset dropped asynchronously mid-cycle at Count=40 -> Count=0 and Pulse=0 immediately; the next pulse comes 50 edges after release.
REQ-031 Clear asserted while Count=49 -> no pulse; Count=0 at the next edge.
REQ-032 PERIOD=1 -> Pulse high every cycle; PERIOD=2 -> Pulse alternates 0,1,0,1 starting after edge 2.
